interrupt_controller: RTL and testbench

Interrupt source side of the processor's interrupt handshake. Collects up to `N_SRC` external request lines, latches rising edges as pending, applies a software mask, and picks the highest-priority source. It then drives the single-cycle `interrupt` pulse that the jump control logic uses to save the return address and redirect the PC to the handler at 16'hF000. It blocks nesting until the handler's RET executes, because only one return address is held downstream.

---
 rtl/interrupt_controller.sv | 133 +++++++++++++
 tb/tb_interrupt_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-captured, maskable, lowest-index-first interrupt
// source. Drives a one-cycle request pulse to jump control and blocks nesting
// until the handler's RET, since only one return address is held downstream.
module interrupt_controller #(
   parameter int N_SRC     = 8,
   parameter int ENTRY_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [5:0]       op,
   input  logic             int_en,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   output logic             interrupt,
   output logic [3:0]       irq_id,
   output logic             in_service,
   output logic [N_SRC-1:0] pending,
   output logic [N_SRC-1:0] mask
);

   localparam logic [5:0]       OP_RET  = 6'b010000;
   localparam int               CW      = (ENTRY_CYC > 1) ? $clog2(ENTRY_CYC) : 1;
   localparam logic [N_SRC-1:0] SRC_ONE = {{(N_SRC-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_ENTRY, S_SERVICE, S_COOLDOWN
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       irq_id_q, irq_id_d;
   logic             in_service_q, in_service_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] irq_q, irq_d;

   logic [N_SRC-1:0] edge_vec, eligible, clr_vec;
   logic [3:0]       win_id;
   logic             win_vld;
   logic             ctl_op;

   // Control-transfer ops: firing during one would corrupt the saved return address
   always_comb begin
      ctl_op = op inside {6'b011100, 6'b011101, 6'b011110, 6'b011111, 6'b011000, OP_RET};
   end

   // Edge detect and lowest-index-first arbitration over unmasked pending
   always_comb begin
      edge_vec = irq_in & ~irq_q;
      eligible = pending_q & ~mask_q;
      win_id   = '0;
      win_vld  = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_id  = 4'(i);
            win_vld = 1'b1;
         end
      end
   end

   // Pulse only while armed and the current op is safe to interrupt
   always_comb begin
      interrupt = (state_q == S_ARMED) && !ctl_op;
   end

   // Next-state: handshake FSM, pending set/clear (set wins), mask and edge history
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      irq_id_d     = irq_id_q;
      in_service_d = in_service_q;
      clr_vec      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld && int_en) begin
               state_d  = S_ARMED;
               irq_id_d = win_id;
            end
         end
         S_ARMED: begin
            if (!ctl_op) begin
               state_d      = S_ENTRY;
               in_service_d = 1'b1;
               cnt_d        = CW'(ENTRY_CYC - 1);
               clr_vec      = SRC_ONE << irq_id_q;
            end
         end
         S_ENTRY: begin
            if (cnt_q == '0) state_d = S_SERVICE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_SERVICE: begin
            if (op == OP_RET) begin
               state_d      = S_COOLDOWN;
               in_service_d = 1'b0;
            end
         end
         S_COOLDOWN: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      pending_d = (pending_q & ~clr_vec) | edge_vec;
      mask_d    = mask_we ? mask_wdata : mask_q;
      irq_d     = irq_in;
   end

   // State registers with synchronous reset; reset masks every source
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         irq_id_q     <= '0;
         in_service_q <= 1'b0;
         pending_q    <= '0;
         mask_q       <= '1;
         irq_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         irq_id_q     <= irq_id_d;
         in_service_q <= in_service_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         irq_q        <= irq_d;
      end
   end

   assign irq_id     = irq_id_q;
   assign in_service = in_service_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs are driven 1 time unit after
// each rising edge and outputs are sampled 3 units after it.
module tb_interrupt_controller;

   localparam logic [5:0] RET = 6'b010000;
   localparam logic [5:0] JMP = 6'b011000;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic [5:0] op;
   logic       int_en;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       interrupt;
   logic [3:0] irq_id;
   logic       in_service;
   logic [7:0] pending;
   logic [7:0] mask;

   int n_chk  = 0;
   int n_pass = 0;

   interrupt_controller #(.N_SRC(8), .ENTRY_CYC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .op         (op),
      .int_en     (int_en),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .interrupt  (interrupt),
      .irq_id     (irq_id),
      .in_service (in_service),
      .pending    (pending),
      .mask       (mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; irq_in = '0; op = '0; int_en = 1'b1; mask_we = 1'b0; mask_wdata = '0;
      cyc(2);
      reset = 1'b0; #2;
      chk("rst_interrupt", interrupt, 0);
      chk("rst_in_service", in_service, 0);
      chk("rst_irq_id", irq_id, 0);
      chk("rst_pending", pending, 8'h00);
      chk("rst_mask", mask, 8'hFF);

      cyc(1); mask_we = 1'b1; mask_wdata = 8'h00;
      cyc(1); mask_we = 1'b0; #2;
      chk("mask_write", mask, 8'h00);

      // Single source 3: pending next cycle, pulse one cycle later
      cyc(1); irq_in = 8'h08; #2;                 // n
      chk("t1_no_early_pulse", interrupt, 0);
      cyc(1); irq_in = 8'h00; #2;                 // n+1
      chk("t1_pending", pending, 8'h08);
      chk("t1_no_pulse_n1", interrupt, 0);
      cyc(1); #2;                                 // n+2
      chk("t1_pulse", interrupt, 1);
      cyc(1); op = RET; #2;                       // n+3 ENTRY, RET ignored
      chk("t1_pulse_once", interrupt, 0);
      chk("t1_in_service", in_service, 1);
      chk("t1_irq_id", irq_id, 3);
      chk("t1_pending_clr", pending, 8'h00);
      cyc(1); #2;                                 // n+4 ENTRY
      chk("t1_entry_ret_ign", in_service, 1);
      cyc(1); op = 6'd0; irq_in = 8'h01; #2;      // n+5 SERVICE, new edge
      chk("t1_service", in_service, 1);
      cyc(1); op = RET; irq_in = 8'h00; #2;       // n+6 RET
      chk("t1_svc_edge_pend", pending, 8'h01);
      chk("t1_svc_no_pulse", interrupt, 0);
      cyc(1); op = 6'd0; #2;                      // n+7 COOLDOWN
      chk("t1_cool_insvc", in_service, 0);
      chk("t1_cool_no_pulse", interrupt, 0);
      cyc(1); #2;                                 // n+8 IDLE
      chk("t1_idle_no_pulse", interrupt, 0);
      cyc(1); #2;                                 // n+9 = RET+3
      chk("t1_src0_pulse", interrupt, 1);
      cyc(1); #2;                                 // n+10 ENTRY
      chk("t1_src0_id", irq_id, 0);
      chk("t1_src0_insvc", in_service, 1);
      cyc(1);                                     // n+11 ENTRY
      cyc(1); op = RET;                           // n+12 SERVICE
      cyc(1); op = 6'd0;                          // n+13 COOLDOWN

      // Simultaneous edges on 5 and 2: 2 wins, 5 follows RET by 3 cycles
      cyc(1); irq_in = 8'h24;                     // c
      cyc(1); irq_in = 8'h00; #2;                 // c+1
      chk("t2_pending", pending, 8'h24);
      cyc(1); #2;                                 // c+2
      chk("t2_pulse", interrupt, 1);
      cyc(1); #2;                                 // c+3
      chk("t2_first_id", irq_id, 2);
      chk("t2_pending_left", pending, 8'h20);
      cyc(1);                                     // c+4
      cyc(1); op = RET;                           // c+5 SERVICE, RET
      cyc(1); op = 6'd0; #2;                      // c+6
      chk("t2_insvc_drop", in_service, 0);
      cyc(1); #2;                                 // c+7
      chk("t2_no_pulse_r2", interrupt, 0);
      cyc(1); #2;                                 // c+8
      chk("t2_src5_pulse", interrupt, 1);
      cyc(1); #2;                                 // c+9
      chk("t2_second_id", irq_id, 5);
      chk("t2_pending_empty", pending, 8'h00);
      cyc(1);                                     // c+10
      cyc(1); op = RET;                           // c+11 SERVICE
      cyc(1); op = 6'd0;                          // c+12 COOLDOWN

      // Control-transfer ops hold off the pulse; set beats clear on collision
      cyc(1); irq_in = 8'h10;                     // d
      cyc(1); irq_in = 8'h00; #2;                 // d+1
      chk("t3_pending", pending, 8'h10);
      for (int i = 0; i < 4; i++) begin           // d+2..d+5 ARMED
         cyc(1); op = JMP; #2;
         chk("t3_ctl_hold", interrupt, 0);
      end
      cyc(1); op = 6'd0; irq_in = 8'h10; #2;      // d+6
      chk("t3_pulse_after_ctl", interrupt, 1);
      cyc(1); irq_in = 8'h00; mask_we = 1'b1; mask_wdata = 8'hFF; #2;  // d+7
      chk("t3_insvc", in_service, 1);
      chk("t3_irq_id", irq_id, 4);
      chk("t3_set_wins", pending, 8'h10);
      cyc(1); mask_we = 1'b0; #2;                 // d+8
      chk("t3_mask_ff", mask, 8'hFF);
      cyc(1); op = RET;                           // d+9 SERVICE
      cyc(1); op = 6'd0; #2;                      // d+10
      chk("t3_insvc_drop", in_service, 0);
      cyc(1);                                     // d+11 IDLE, all masked

      // Masked edge still pends; unmasking arms within two cycles
      cyc(1); irq_in = 8'h02; #2;                 // d+12
      chk("t4_masked_no_pulse", interrupt, 0);
      cyc(1); irq_in = 8'h00; #2;                 // d+13
      chk("t4_masked_pending", pending, 8'h12);
      cyc(1); mask_we = 1'b1; mask_wdata = 8'h00; #2;  // d+14
      chk("t4_still_quiet", interrupt, 0);
      cyc(1); mask_we = 1'b0; #2;                 // d+15
      chk("t4_mask_00", mask, 8'h00);
      chk("t4_no_pulse_yet", interrupt, 0);
      cyc(1); #2;                                 // d+16
      chk("t4_unmask_pulse", interrupt, 1);
      cyc(1); #2;                                 // d+17
      chk("t4_irq_id", irq_id, 1);
      chk("t4_pending", pending, 8'h10);
      cyc(1);                                     // d+18 ENTRY
      cyc(1); #2;                                 // d+19 SERVICE
      chk("t5_pre_rst_insvc", in_service, 1);
      reset = 1'b1; irq_in = 8'h08;
      cyc(1); reset = 1'b0; irq_in = 8'h00; #2;   // d+20
      chk("t5_rst_insvc", in_service, 0);
      chk("t5_rst_pending", pending, 8'h00);
      chk("t5_rst_mask", mask, 8'hFF);
      chk("t5_rst_interrupt", interrupt, 0);
      chk("t5_rst_irq_id", irq_id, 0);
      cyc(1); #2;
      chk("t5_post_rst_quiet", interrupt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
